// File: rtl/line_stream_sequencer.sv
// Paces an image pixel stream into the edge detector: pre-fills PREFILL_LINES lines, then releases
// one line per detector interrupt credit, then appends PAD_LINES constant lines to flush the window.
module line_stream_sequencer #(
   parameter int                DATA_W        = 8,
   parameter int                IMG_W         = 512,
   parameter int                IMG_H         = 512,
   parameter int                PREFILL_LINES = 4,
   parameter int                PAD_LINES     = 2,
   parameter logic [DATA_W-1:0] PAD_VALUE     = '0,
   localparam int               CW            = $clog2(IMG_H + PAD_LINES + 1)
) (
   input  logic              axi_clk,
   input  logic              axi_reset_n,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_data_valid,
   output logic              s_data_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_data_valid,
   input  logic              m_data_ready,
   input  logic              i_intr,
   output logic              o_busy,
   output logic              o_done,
   output logic [CW-1:0]     o_line_cnt
);

   localparam int PW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic [PW-1:0] LAST_PIX   = PW'(IMG_W - 1);
   localparam logic [CW-1:0] PREFILL_N  = CW'(PREFILL_LINES);
   localparam logic [CW-1:0] IMG_N      = CW'(IMG_H);
   localparam logic [CW-1:0] TOTAL_N    = CW'(IMG_H + PAD_LINES);
   localparam logic [CW-1:0] CREDIT_MAX = '1;

   typedef enum logic [2:0] {
      IDLE, PREFILL, WAIT_CR, IMG_LINE, PAD_LINE, DONE
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [PW-1:0] r_pix_cnt;
   logic [CW-1:0] r_line_cnt;
   logic [CW-1:0] r_credit;
   logic          r_intr_q;

   logic          w_img;
   logic          w_pad;
   logic          w_beat;
   logic          w_line_end;
   logic          w_seq_end;
   logic          w_rise;
   logic          w_consume;
   logic          w_have_credit;
   logic          w_clear;
   logic [CW-1:0] w_lines_done;

   assign w_img        = (r_state == PREFILL) || (r_state == IMG_LINE);
   assign w_pad        = (r_state == PAD_LINE);
   assign m_data       = w_img ? s_data : (w_pad ? PAD_VALUE : '0);
   assign m_data_valid = w_img ? s_data_valid : w_pad;
   assign s_data_ready = w_img & m_data_ready;

   assign w_beat        = m_data_valid & m_data_ready;
   assign w_line_end    = w_beat && (r_pix_cnt == LAST_PIX);
   assign w_lines_done  = r_line_cnt + CW'(1);
   // Inside PREFILL only the last pre-filled line is a pacing decision point.
   assign w_seq_end     = w_line_end && ((r_state != PREFILL) || (w_lines_done == PREFILL_N));
   assign w_have_credit = (r_credit != '0);
   assign w_rise        = i_intr && !r_intr_q && (r_state != IDLE) && (r_state != DONE);
   assign w_clear       = i_abort || ((r_state == IDLE) && i_start);

   assign o_busy     = (r_state != IDLE);
   assign o_done     = (r_state == DONE);
   assign o_line_cnt = r_line_cnt;

   always_comb begin
      w_state_nxt = r_state;
      w_consume   = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) w_state_nxt = PREFILL;
         end
         PREFILL, IMG_LINE, PAD_LINE: begin
            if (w_seq_end) begin
               if (w_lines_done == TOTAL_N) begin
                  w_state_nxt = DONE;
               end else if (w_have_credit) begin
                  w_consume   = 1'b1;
                  w_state_nxt = (w_lines_done < IMG_N) ? IMG_LINE : PAD_LINE;
               end else begin
                  w_state_nxt = WAIT_CR;
               end
            end
         end
         WAIT_CR: begin
            if (w_have_credit) begin
               w_consume   = 1'b1;
               w_state_nxt = (r_line_cnt < IMG_N) ? IMG_LINE : PAD_LINE;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (i_abort) begin
         w_state_nxt = IDLE;
         w_consume   = 1'b0;
      end
   end

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         r_state    <= IDLE;
         r_pix_cnt  <= '0;
         r_line_cnt <= '0;
         r_credit   <= '0;
         r_intr_q   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_intr_q <= i_intr;
         if (w_clear) begin
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
            r_credit   <= '0;
         end else begin
            if (w_beat) r_pix_cnt <= (r_pix_cnt == LAST_PIX) ? '0 : r_pix_cnt + PW'(1);
            if (w_line_end) r_line_cnt <= w_lines_done;
            // A rise and a consume in the same cycle cancel out.
            if (w_rise && !w_consume && (r_credit != CREDIT_MAX)) r_credit <= r_credit + CW'(1);
            else if (w_consume && !w_rise) r_credit <= r_credit - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_line_stream_sequencer.sv
// Bench for line_stream_sequencer: 4x6 image, 4 pre-fill lines, 2 pad lines, counting source.
module tb_line_stream_sequencer;

   localparam int          DATA_W        = 8;
   localparam int          IMG_W         = 4;
   localparam int          IMG_H         = 6;
   localparam int          PREFILL_LINES = 4;
   localparam int          PAD_LINES     = 2;
   localparam logic [7:0]  PAD_VALUE     = 8'hA5;
   localparam int          CW            = $clog2(IMG_H + PAD_LINES + 1);
   localparam int          FRAME_BEATS   = (IMG_H + PAD_LINES) * IMG_W;

   logic              axi_clk = 1'b0;
   logic              axi_reset_n;
   logic              i_start, i_abort, i_intr;
   logic [DATA_W-1:0] s_data;
   logic              s_data_valid, s_data_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_data_valid, m_data_ready;
   logic              o_busy, o_done;
   logic [CW-1:0]     o_line_cnt;

   line_stream_sequencer #(
      .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .PREFILL_LINES(PREFILL_LINES),
      .PAD_LINES(PAD_LINES), .PAD_VALUE(PAD_VALUE)
   ) dut (
      .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .i_start(i_start), .i_abort(i_abort),
      .s_data(s_data), .s_data_valid(s_data_valid), .s_data_ready(s_data_ready),
      .m_data(m_data), .m_data_valid(m_data_valid), .m_data_ready(m_data_ready),
      .i_intr(i_intr), .o_busy(o_busy), .o_done(o_done), .o_line_cnt(o_line_cnt)
   );

   always #5 axi_clk = ~axi_clk;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [7:0] src_val = 8'h00;
   logic [7:0] frame_start = 8'h00;
   bit         rand_v = 0;
   bit         rand_r = 0;
   logic [7:0] obs_dat[$];
   int         obs_cyc[$];
   bit         obs_srdy[$];
   int         done_cnt = 0;
   int         done_cyc = -1;

   // Reference: image pixels are the source sequence in order, then pad pixels.
   function automatic logic [7:0] exp_pix(int k);
      logic [7:0] v;
      if (k < IMG_H * IMG_W) v = frame_start + 8'(k);
      else v = PAD_VALUE;
      return v;
   endfunction

   function automatic int exp_released(int credits);
      int lines;
      lines = PREFILL_LINES + credits;
      if (lines > IMG_H + PAD_LINES) lines = IMG_H + PAD_LINES;
      return lines * IMG_W;
   endfunction

   task automatic step();
      bit took;
      @(negedge axi_clk);
      if (m_data_valid && m_data_ready) begin
         obs_dat.push_back(m_data);
         obs_cyc.push_back(cyc);
         obs_srdy.push_back(s_data_ready);
      end
      if (o_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      took = s_data_valid && s_data_ready;
      @(posedge axi_clk);
      #1;
      cyc++;
      if (took) src_val = src_val + 8'd1;
      s_data       = src_val;
      s_data_valid = rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
      m_data_ready = rand_r ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic run(int n);
      repeat (n) step();
   endtask

   task automatic new_frame();
      obs_dat.delete();
      obs_cyc.delete();
      obs_srdy.delete();
      done_cnt = 0;
      done_cyc = -1;
   endtask

   task automatic start_frame(output int t0);
      new_frame();
      frame_start = src_val;
      t0 = cyc;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
   endtask

   task automatic pulse_intr();
      i_intr = 1'b1;
      step();
      i_intr = 1'b0;
      step();
   endtask

   task automatic test_reset();
      int t0;
      run(3);
      checks++;
      if ({m_data, m_data_valid, s_data_ready, o_busy, o_done, o_line_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0",
                  {m_data, m_data_valid, s_data_ready, o_busy, o_done, o_line_cnt});
      end
      axi_reset_n = 1'b1;
      run(2);
      start_frame(t0);
      run(5);
      checks++;
      if (o_busy !== 1'b1 || m_data_valid !== 1'b1) begin
         errors++;
         $display("FAIL prefill_active busy=%b valid=%b want 1 1", o_busy, m_data_valid);
      end
      axi_reset_n = 1'b0;
      #1;
      checks++;
      if ({m_data, m_data_valid, s_data_ready, o_busy, o_done, o_line_cnt} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got %h want 0",
                  {m_data, m_data_valid, s_data_ready, o_busy, o_done, o_line_cnt});
      end
      run(3);
      axi_reset_n = 1'b1;
      new_frame();
      run(10);
      checks++;
      if (obs_dat.size() != 0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle beats=%0d busy=%b want 0 0", obs_dat.size(), o_busy);
      end
   endtask

   task automatic test_prefill();
      int t0, gaps;
      rand_v = 0;
      rand_r = 0;
      start_frame(t0);
      run(25);
      checks++;
      if (obs_dat.size() != exp_released(0)) begin
         errors++;
         $display("FAIL prefill_beats got %0d want %0d", obs_dat.size(), exp_released(0));
      end
      gaps = 0;
      for (int k = 0; k < obs_dat.size(); k++) begin
         checks++;
         if (obs_dat[k] !== exp_pix(k)) begin
            errors++;
            $display("FAIL prefill_data[%0d] got %h want %h", k, obs_dat[k], exp_pix(k));
         end
         if (obs_cyc[k] != t0 + 1 + k) gaps++;
      end
      checks++;
      if (gaps != 0) begin
         errors++;
         $display("FAIL prefill_timing misplaced=%0d want 0", gaps);
      end
      checks++;
      if (o_line_cnt !== CW'(4) || m_data_valid !== 1'b0 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL prefill_stall lines=%0d valid=%b busy=%b want 4 0 1",
                  o_line_cnt, m_data_valid, o_busy);
      end
   endtask

   task automatic test_one_credit();
      int t0, base, gaps;
      base = obs_dat.size();
      t0 = cyc;
      // A level held for three cycles is still a single credit.
      i_intr = 1'b1;
      run(3);
      i_intr = 1'b0;
      run(12);
      checks++;
      if (obs_dat.size() - base != IMG_W) begin
         errors++;
         $display("FAIL credit_beats got %0d want %0d", obs_dat.size() - base, IMG_W);
      end
      gaps = 0;
      for (int k = base; k < obs_dat.size(); k++) begin
         checks++;
         if (obs_dat[k] !== exp_pix(k)) begin
            errors++;
            $display("FAIL credit_data[%0d] got %h want %h", k, obs_dat[k], exp_pix(k));
         end
         if (obs_cyc[k] != t0 + 2 + (k - base)) gaps++;
      end
      checks++;
      if (gaps != 0) begin
         errors++;
         $display("FAIL credit_timing misplaced=%0d want 0", gaps);
      end
      checks++;
      if (o_line_cnt !== CW'(5) || m_data_valid !== 1'b0) begin
         errors++;
         $display("FAIL credit_stall lines=%0d valid=%b want 5 0", o_line_cnt, m_data_valid);
      end
   endtask

   task automatic test_pad_lines();
      int t0, base, gaps, bad;
      pulse_intr();
      run(8);
      checks++;
      if (o_line_cnt !== CW'(6) || obs_dat.size() != 6 * IMG_W) begin
         errors++;
         $display("FAIL last_img_line lines=%0d beats=%0d want 6 %0d",
                  o_line_cnt, obs_dat.size(), 6 * IMG_W);
      end
      base = obs_dat.size();
      t0 = cyc;
      pulse_intr();
      pulse_intr();
      run(12);
      checks++;
      if (obs_dat.size() - base != 2 * IMG_W) begin
         errors++;
         $display("FAIL pad_beats got %0d want %0d", obs_dat.size() - base, 2 * IMG_W);
      end
      gaps = 0;
      bad = 0;
      for (int k = base; k < obs_dat.size(); k++) begin
         checks++;
         if (obs_dat[k] !== PAD_VALUE || obs_srdy[k] !== 1'b0) begin
            errors++;
            $display("FAIL pad_data[%0d] got %h srdy=%b want %h 0",
                     k, obs_dat[k], obs_srdy[k], PAD_VALUE);
         end
         if (obs_cyc[k] != t0 + 2 + (k - base)) gaps++;
      end
      checks++;
      if (gaps != 0) begin
         errors++;
         $display("FAIL pad_timing misplaced=%0d want 0", gaps);
      end
      checks++;
      if (done_cnt != 1 || obs_cyc.size() == 0 || done_cyc != obs_cyc[obs_cyc.size() - 1] + 1) begin
         errors++;
         $display("FAIL done_pulse count=%0d cyc=%0d want 1 after last beat", done_cnt, done_cyc);
      end
      checks++;
      if (obs_dat.size() != FRAME_BEATS || o_line_cnt !== CW'(8) || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL frame_end beats=%0d lines=%0d busy=%b want %0d 8 0",
                  obs_dat.size(), o_line_cnt, o_busy, FRAME_BEATS);
      end
   endtask

   task automatic test_back_to_back();
      int t0, gaps;
      start_frame(t0);
      step();
      pulse_intr();
      step();
      pulse_intr();
      run(30);
      checks++;
      if (obs_dat.size() != exp_released(2)) begin
         errors++;
         $display("FAIL b2b_beats got %0d want %0d", obs_dat.size(), exp_released(2));
      end
      gaps = 0;
      for (int k = 0; k < obs_dat.size(); k++) begin
         if (obs_cyc[k] != t0 + 1 + k) gaps++;
      end
      checks++;
      if (gaps != 0) begin
         errors++;
         $display("FAIL b2b_timing misplaced=%0d want 0", gaps);
      end
      checks++;
      if (o_line_cnt !== CW'(6) || m_data_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_stall lines=%0d valid=%b want 6 0", o_line_cnt, m_data_valid);
      end
      pulse_intr();
      run(10);
      checks++;
      if (obs_dat.size() != exp_released(3) || done_cnt != 0) begin
         errors++;
         $display("FAIL b2b_credit_drained beats=%0d done=%0d want %0d 0",
                  obs_dat.size(), done_cnt, exp_released(3));
      end
      pulse_intr();
      run(10);
      for (int k = 0; k < obs_dat.size(); k++) begin
         checks++;
         if (obs_dat[k] !== exp_pix(k)) begin
            errors++;
            $display("FAIL b2b_data[%0d] got %h want %h", k, obs_dat[k], exp_pix(k));
         end
      end
      checks++;
      if (obs_dat.size() != FRAME_BEATS || done_cnt != 1) begin
         errors++;
         $display("FAIL b2b_frame beats=%0d done=%0d want %0d 1", obs_dat.size(), done_cnt, FRAME_BEATS);
      end
   endtask

   task automatic test_throttle_abort();
      int t0, n, kept;
      rand_v = 1;
      rand_r = 1;
      start_frame(t0);
      pulse_intr();
      pulse_intr();
      n = 0;
      while (obs_dat.size() < exp_released(0) + 2 && n < 400) begin
         step();
         n++;
      end
      checks++;
      if (obs_dat.size() < exp_released(0) + 2) begin
         errors++;
         $display("FAIL abort_reach beats=%0d want >=%0d", obs_dat.size(), exp_released(0) + 2);
      end
      i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      kept = obs_dat.size();
      for (int k = 0; k < kept; k++) begin
         checks++;
         if (obs_dat[k] !== exp_pix(k)) begin
            errors++;
            $display("FAIL throttle_data[%0d] got %h want %h", k, obs_dat[k], exp_pix(k));
         end
      end
      checks++;
      if (o_busy !== 1'b0 || m_data_valid !== 1'b0 || s_data_ready !== 1'b0 || o_line_cnt !== '0) begin
         errors++;
         $display("FAIL abort_idle busy=%b valid=%b srdy=%b lines=%0d want 0 0 0 0",
                  o_busy, m_data_valid, s_data_ready, o_line_cnt);
      end
      run(10);
      checks++;
      if (done_cnt != 0 || obs_dat.size() != kept) begin
         errors++;
         $display("FAIL abort_quiet done=%0d extra_beats=%0d want 0 0", done_cnt, obs_dat.size() - kept);
      end
      // The credit left over from the aborted frame must not release a line.
      start_frame(t0);
      n = 0;
      while (obs_dat.size() < exp_released(0) && n < 400) begin
         step();
         n++;
      end
      run(30);
      checks++;
      if (obs_dat.size() != exp_released(0)) begin
         errors++;
         $display("FAIL restart_prefill beats=%0d want %0d", obs_dat.size(), exp_released(0));
      end
      repeat (4) pulse_intr();
      n = 0;
      while (done_cnt == 0 && n < 600) begin
         step();
         n++;
      end
      step();
      for (int k = 0; k < obs_dat.size(); k++) begin
         checks++;
         if (obs_dat[k] !== exp_pix(k)) begin
            errors++;
            $display("FAIL restart_data[%0d] got %h want %h", k, obs_dat[k], exp_pix(k));
         end
      end
      checks++;
      if (obs_dat.size() != FRAME_BEATS || done_cnt != 1 || o_line_cnt !== CW'(8)) begin
         errors++;
         $display("FAIL restart_frame beats=%0d done=%0d lines=%0d want %0d 1 8",
                  obs_dat.size(), done_cnt, o_line_cnt, FRAME_BEATS);
      end
      rand_v = 0;
      rand_r = 0;
   endtask

   initial begin
      axi_reset_n  = 1'b0;
      i_start      = 1'b0;
      i_abort      = 1'b0;
      i_intr       = 1'b0;
      s_data       = 8'h00;
      s_data_valid = 1'b1;
      m_data_ready = 1'b1;
      test_reset();
      test_prefill();
      test_one_credit();
      test_pad_lines();
      test_back_to_back();
      test_throttle_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
